pid_core: RTL and testbench
===========================

PID_CORE -- requirements
Module: pid_core

Interface
REQ-001 SHALL have parameter DWI, default 14, input and set-point width (signed).
REQ-002 SHALL have parameter DWO, default 14, output width (signed).
REQ-003 SHALL have parameter DWK, default 14, gain width (signed).
REQ-004 SHALL have parameter IW, default 32, integrator accumulator width.
REQ-005 SHALL have parameters PSR, ISR, DSR, defaults 12, 18, 10, right-shift amounts for the P, I and D terms.
REQ-006 SHALL have port clk, input, 1 bit, the only clock.
REQ-007 SHALL have port rstn, input, 1 bit, reset that is asynchronous and active-low.
REQ-008 SHALL have ports sti_dat input DWI, sti_vld input 1, sti_rdy output 1: input sample stream.
REQ-009 SHALL have ports sto_dat output DWO, sto_vld output 1, sto_rdy input 1: output stream.
REQ-010 SHALL have ports set_sp input DWI, and set_kp, set_ki, set_kd input DWK each: set point and gains.
REQ-011 SHALL have ports set_min and set_max, input DWO each: output clamp limits.
REQ-012 SHALL have ports int_rst input 1 (clear integrator) and int_hold input 1 (freeze integrator).
REQ-013 SHALL have port sat_o, output, 2 bits: {clamped_high, clamped_low} for the current sto_dat.

Function
REQ-014 SHALL use a 3-stage pipeline: S1 error, S2 terms/integrator, S3 sum/clamp; the global advance condition is adv = !(sto_vld && !sto_rdy).
REQ-015 SHALL drive sti_rdy = adv; a sample is accepted when sti_vld && sti_rdy.
REQ-016 SHALL carry a valid bit per stage; bubbles propagate, and the stage registers and valid bits change only when adv=1.
REQ-017 SHALL produce latency of exactly 3 clk cycles from acceptance to sto_vld when sto_rdy is held high, with full throughput of 1 sample/cycle.
REQ-018 SHALL compute S1 err = set_sp - sti_dat at DWI+1 bits, with no overflow possible.
REQ-019 SHALL compute the S2 P term as (err*set_kp) arithmetic-shifted right by PSR.
REQ-020 SHALL compute S2 D = (err*set_kd >>> DSR) minus the same value from the previous valid sample; bubbles SHALL NOT update the D history.
REQ-021 SHALL update the S2 integrator only on a valid S1 sample with adv=1: acc <= sat_IW(acc + err*set_ki).
REQ-022 SHALL saturate the integrator to the signed IW range, with no wrap-around.
REQ-023 SHALL apply integrator priority int_rst > int_hold > anti-windup > update; int_rst clears acc on any cycle regardless of adv or valid.
REQ-024 SHALL apply anti-windup: skip the update when sat_o[1]=1 and err*set_ki>0, or when sat_o[0]=1 and err*set_ki<0.
REQ-025 SHALL compute S3 sum = P + (acc >>> ISR) + D at full precision, with no intermediate truncation.
REQ-026 SHALL clamp the S3 sum: if sum>set_max, sto_dat=set_max and sat_o=2'b10; else if sum<set_min, sto_dat=set_min and sat_o=2'b01; else sto_dat=sum and sat_o=2'b00.
REQ-027 SHALL resolve set_min>set_max by giving the low clamp precedence: sto_dat=set_min and sat_o=2'b01.
REQ-028 SHALL hold sto_dat, sto_vld and sat_o stable while sto_vld && !sto_rdy.
REQ-029 SHALL sample configuration inputs live; a change affects only samples entering the corresponding stage afterwards.

Reset
REQ-030 SHALL, while rstn=0, asynchronously clear all stage registers, valid bits, the integrator and the D history.
REQ-031 SHALL hold outputs at sto_dat=0, sto_vld=0, sat_o=0 and sti_rdy=1 while rstn=0 and after reset release.
REQ-032 SHALL discard in-flight samples on reset mid-operation; the first output after reset comes 3 cycles after the first accepted sample.

Structure
REQ-033 SHALL place default widths and shifts, and the 2-bit saturation-flag encoding, as constants in shared package pid_pkg.
REQ-034 SHALL contain one sub-module, pid_sat, a generic signed saturate/clamp instantiated for both the integrator and the output.

Verification
REQ-035 SHALL verify P-only: kp=4096, ki=kd=0, sp=0, sti_dat=-100 -> sto_dat=100 three cycles after acceptance, sat_o=00.
REQ-036 SHALL verify clamp: kp=8191, sp=8191, dat=-8192, set_max=1000 -> sto_dat=1000, sat_o=10; with set_min=-500 and inverted error -> -500, sat_o=01.
REQ-037 SHALL verify anti-windup: ki=8191, constant positive error, set_max=100 -> acc stops growing once sat_o=10; after error reversal the output leaves the clamp within 2 samples.
REQ-038 SHALL verify backpressure: random sto_rdy over 1000 random samples -> output sequence equals the reference model, with no loss or duplication and stable data during stalls.
REQ-039 SHALL verify int_rst and int_hold: after accumulation, assert int_hold for 10 samples -> acc unchanged; then pulse int_rst for 1 cycle -> acc=0 next cycle.
REQ-040 SHALL verify mid-stream reset: rstn low for 1 cycle with 3 samples in flight -> sto_vld=0 immediately and D history cleared.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared defaults and saturation-flag encoding for the PID core.
package pid_pkg;

  localparam int unsigned DEF_DWI = 14;
  localparam int unsigned DEF_DWO = 14;
  localparam int unsigned DEF_DWK = 14;
  localparam int unsigned DEF_IW  = 32;
  localparam int unsigned DEF_PSR = 12;
  localparam int unsigned DEF_ISR = 18;
  localparam int unsigned DEF_DSR = 10;

  // {clamped_high, clamped_low}
  typedef enum logic [1:0] {
    SAT_NONE = 2'b00,
    SAT_LOW  = 2'b01,
    SAT_HIGH = 2'b10
  } sat_e;

endpackage

// File: rtl/pid_sat.sv
// Generic signed clamp of a wide value into [lo, hi]; lo wins when lo > hi.
module pid_sat
  import pid_pkg::*;
#(
  parameter int unsigned WI = 16,
  parameter int unsigned WO = 8
) (
  input  logic signed [WI-1:0] din,
  input  logic signed [WO-1:0] lo,
  input  logic signed [WO-1:0] hi,
  output logic signed [WO-1:0] dout,
  output sat_e                 flags
);

  logic signed [WI-1:0] lo_x;
  logic signed [WI-1:0] hi_x;

  assign lo_x = WI'(lo);
  assign hi_x = WI'(hi);

  always_comb begin
    dout  = WO'(din);
    flags = SAT_NONE;
    if ((lo_x > hi_x) || (din < lo_x)) begin
      dout  = lo;
      flags = SAT_LOW;
    end else if (din > hi_x) begin
      dout  = hi;
      flags = SAT_HIGH;
    end
  end

endmodule

// File: rtl/pid_core.sv
// Three-stage streaming PID: error, P/I/D terms with saturating integrator, sum and clamp.
module pid_core
  import pid_pkg::*;
#(
  parameter int unsigned DWI = DEF_DWI,
  parameter int unsigned DWO = DEF_DWO,
  parameter int unsigned DWK = DEF_DWK,
  parameter int unsigned IW  = DEF_IW,
  parameter int unsigned PSR = DEF_PSR,
  parameter int unsigned ISR = DEF_ISR,
  parameter int unsigned DSR = DEF_DSR
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic signed [DWI-1:0] sti_dat,
  input  logic                  sti_vld,
  output logic                  sti_rdy,
  output logic signed [DWO-1:0] sto_dat,
  output logic                  sto_vld,
  input  logic                  sto_rdy,
  input  logic signed [DWI-1:0] set_sp,
  input  logic signed [DWK-1:0] set_kp,
  input  logic signed [DWK-1:0] set_ki,
  input  logic signed [DWK-1:0] set_kd,
  input  logic signed [DWO-1:0] set_min,
  input  logic signed [DWO-1:0] set_max,
  input  logic                  int_rst,
  input  logic                  int_hold,
  output logic [1:0]            sat_o
);

  localparam int unsigned EW = DWI + 1;
  localparam int unsigned PW = EW + DWK;
  localparam int unsigned DW = PW + 1;
  localparam int unsigned AW = ((IW > PW) ? IW : PW) + 1;
  localparam int unsigned SW = ((DW > IW) ? DW : IW) + 2;

  localparam logic signed [IW-1:0] ACC_MAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] ACC_MIN = {1'b1, {(IW-1){1'b0}}};

  logic                 adv;
  logic                 s1_vld;
  logic signed [EW-1:0] s1_err;
  logic                 s2_vld;
  logic signed [PW-1:0] s2_p;
  logic signed [DW-1:0] s2_d;
  logic signed [PW-1:0] d_hist;
  logic signed [IW-1:0] acc;

  logic signed [PW-1:0] prod_p;
  logic signed [PW-1:0] prod_i;
  logic signed [PW-1:0] prod_d;
  logic signed [PW-1:0] term_d;
  logic                 windup;
  logic signed [AW-1:0] acc_sum;
  logic signed [IW-1:0] acc_next;
  sat_e                 acc_flags_unused;
  logic signed [IW-1:0] acc_shr;
  logic signed [SW-1:0] sum;
  logic signed [DWO-1:0] clamp_dat;
  sat_e                 clamp_flags;

  // Whole pipeline moves together unless the output register is stalled.
  assign adv     = !(sto_vld && !sto_rdy);
  assign sti_rdy = adv;

  // S1: error at one extra bit so the subtraction cannot overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld <= 1'b0;
      s1_err <= '0;
    end else if (adv) begin
      s1_vld <= sti_vld;
      if (sti_vld) s1_err <= EW'(set_sp) - EW'(sti_dat);
    end
  end

  assign prod_p = PW'(s1_err) * PW'(set_kp);
  assign prod_i = PW'(s1_err) * PW'(set_ki);
  assign prod_d = PW'(s1_err) * PW'(set_kd);
  assign term_d = prod_d >>> DSR;

  // S2: P and D terms; D history only advances on real samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld <= 1'b0;
      s2_p   <= '0;
      s2_d   <= '0;
      d_hist <= '0;
    end else if (adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_p   <= prod_p >>> PSR;
        s2_d   <= DW'(term_d) - DW'(d_hist);
        d_hist <= term_d;
      end
    end
  end

  // Block integration that would push further into an active output clamp.
  assign windup  = (sat_o[1] && !prod_i[PW-1] && (prod_i != '0)) ||
                   (sat_o[0] && prod_i[PW-1]);
  assign acc_sum = AW'(acc) + AW'(prod_i);

  pid_sat #(.WI(AW), .WO(IW)) u_acc_sat (
    .din  (acc_sum),
    .lo   (ACC_MIN),
    .hi   (ACC_MAX),
    .dout (acc_next),
    .flags(acc_flags_unused)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (int_rst) begin
      acc <= '0;
    end else if (adv && s1_vld && !int_hold && !windup) begin
      acc <= acc_next;
    end
  end

  // S3: full-precision sum, then clamp to the live output limits.
  assign acc_shr = acc >>> ISR;
  assign sum     = SW'(s2_p) + SW'(acc_shr) + SW'(s2_d);

  pid_sat #(.WI(SW), .WO(DWO)) u_out_sat (
    .din  (sum),
    .lo   (set_min),
    .hi   (set_max),
    .dout (clamp_dat),
    .flags(clamp_flags)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sto_vld <= 1'b0;
      sto_dat <= '0;
      sat_o   <= '0;
    end else if (adv) begin
      sto_vld <= s2_vld;
      if (s2_vld) begin
        sto_dat <= clamp_dat;
        sat_o   <= clamp_flags;
      end
    end
  end

endmodule

// File: tb/tb_pid_core.sv
// Scoreboard bench for pid_core: transaction-level PID model, random backpressure, directed corner cases.
module tb_pid_core;

  localparam int unsigned DWI = 14;
  localparam int unsigned DWO = 14;
  localparam int unsigned DWK = 14;
  localparam int unsigned IW  = 32;
  localparam int unsigned PSR = 12;
  localparam int unsigned ISR = 18;
  localparam int unsigned DSR = 10;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic signed [DWI-1:0] sti_dat;
  logic                  sti_vld;
  logic                  sti_rdy;
  logic signed [DWO-1:0] sto_dat;
  logic                  sto_vld;
  logic                  sto_rdy;
  logic signed [DWI-1:0] set_sp;
  logic signed [DWK-1:0] set_kp;
  logic signed [DWK-1:0] set_ki;
  logic signed [DWK-1:0] set_kd;
  logic signed [DWO-1:0] set_min;
  logic signed [DWO-1:0] set_max;
  logic                  int_rst;
  logic                  int_hold;
  logic [1:0]            sat_o;

  pid_core #(
    .DWI(DWI), .DWO(DWO), .DWK(DWK), .IW(IW), .PSR(PSR), .ISR(ISR), .DSR(DSR)
  ) dut (
    .clk(clk), .rstn(rstn),
    .sti_dat(sti_dat), .sti_vld(sti_vld), .sti_rdy(sti_rdy),
    .sto_dat(sto_dat), .sto_vld(sto_vld), .sto_rdy(sto_rdy),
    .set_sp(set_sp), .set_kp(set_kp), .set_ki(set_ki), .set_kd(set_kd),
    .set_min(set_min), .set_max(set_max),
    .int_rst(int_rst), .int_hold(int_hold), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         dat;
    logic [1:0] sat;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         nvec = 0;
  int         nmis = 0;
  int         cyc = 0;
  longint     m_acc = 0;
  longint     m_dprev = 0;
  logic [1:0] m_sat = 2'b00;
  bit         bp_en = 1'b0;
  bit         chk_lat = 1'b0;
  int         last_dat = 0;
  logic [1:0] last_sat = 2'b00;
  bit         stall_prev = 1'b0;
  logic signed [DWO-1:0] prev_dat_m;
  logic [1:0] prev_sat_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint want);
    nvec++;
    if (got != want) begin
      nmis++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: one PID step per accepted sample, windup judged on the previous output's flags.
  function automatic void model(input int dat, output int odat, output logic [1:0] osat);
    longint err, p, cur, d, pi, s, lo, hi, amax, amin;
    err  = longint'(set_sp) - longint'(dat);
    p    = (err * longint'(set_kp)) >>> PSR;
    cur  = (err * longint'(set_kd)) >>> DSR;
    d    = cur - m_dprev;
    m_dprev = cur;
    pi   = err * longint'(set_ki);
    amax = (longint'(1) <<< (IW - 1)) - 1;
    amin = -(longint'(1) <<< (IW - 1));
    if (!int_hold && !((m_sat == 2'b10 && pi > 0) || (m_sat == 2'b01 && pi < 0))) begin
      m_acc = m_acc + pi;
      if (m_acc > amax) m_acc = amax;
      if (m_acc < amin) m_acc = amin;
    end
    s  = p + (m_acc >>> ISR) + d;
    lo = longint'(set_min);
    hi = longint'(set_max);
    if (lo > hi || s < lo) begin
      odat = int'(lo); osat = 2'b01;
    end else if (s > hi) begin
      odat = int'(hi); osat = 2'b10;
    end else begin
      odat = int'(s);  osat = 2'b00;
    end
    m_sat = osat;
  endfunction

  task automatic send(input int dat);
    exp_t e;
    int   n;
    model(dat, e.dat, e.sat);
    sti_dat = DWI'(dat);
    sti_vld = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (sti_rdy) break;
      n++;
      if (n >= 200) begin
        nvec++; nmis++;
        $display("FAIL accept_timeout got stalled want accepted (cycle %0d)", cyc);
        break;
      end
    end
    e.cyc = cyc;
    sb_q.push_back(e);
    @(posedge clk); #1;
    sti_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      nvec++; nmis++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic send_ser(input int dat);
    send(dat);
    drain();
  endtask

  task automatic pulse_int_rst();
    @(posedge clk); #1;
    int_rst = 1'b1;
    @(posedge clk); #1;
    int_rst = 1'b0;
    m_acc = 0;
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
  endtask

  // Monitor: pops on every output handshake, checks held data during stalls.
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        nvec++;
        if (!(sto_vld && sto_dat == prev_dat_m && sat_o == prev_sat_m)) begin
          nmis++;
          $display("FAIL stall_hold got vld=%0b dat=%0d sat=%b want vld=1 dat=%0d sat=%b",
                   sto_vld, sto_dat, sat_o, prev_dat_m, prev_sat_m);
        end
      end
      if (sto_vld && sto_rdy) begin
        if (sb_q.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL unexpected_out got dat=%0d want no output", sto_dat);
        end else begin
          mon_e = sb_q.pop_front();
          check("out_dat", sto_dat, mon_e.dat);
          check("out_sat", sat_o, mon_e.sat);
          if (chk_lat) check("latency", cyc - mon_e.cyc, 3);
        end
        last_dat = sto_dat;
        last_sat = sat_o;
      end
      stall_prev = sto_vld && !sto_rdy;
      prev_dat_m = sto_dat;
      prev_sat_m = sat_o;
    end
  end

  initial begin
    sto_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      sto_rdy = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint hold_val, clamp_acc;
    int     a, b, t;
    sti_vld = 1'b0; sti_dat = '0;
    set_sp = '0; set_kp = '0; set_ki = '0; set_kd = '0;
    set_min = -14'sd8192; set_max = 14'sd8191;
    int_rst = 1'b0; int_hold = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", sto_vld, 0);
    check("rst_dat", sto_dat, 0);
    check("rst_sat", sat_o, 0);
    check("rst_rdy", sti_rdy, 1);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rel_vld", sto_vld, 0);
    check("rel_rdy", sti_rdy, 1);

    // P-only
    chk_lat = 1'b1;
    set_kp = 14'sd4096;
    send_ser(-100);
    check("p_only_dat", last_dat, 100);
    check("p_only_sat", last_sat, 0);

    // Output clamp high then low
    set_kp = 14'sd8191; set_sp = 14'sd8191; set_max = 14'sd1000;
    send_ser(-8192);
    check("clamp_hi_dat", last_dat, 1000);
    check("clamp_hi_sat", last_sat, 2);
    set_min = -14'sd500; set_sp = -14'sd8192;
    send_ser(8191);
    check("clamp_lo_dat", last_dat, -500);
    check("clamp_lo_sat", last_sat, 1);

    // Anti-windup
    set_kp = '0; set_min = -14'sd8192; set_max = 14'sd100;
    set_ki = 14'sd8191; set_sp = 14'sd100;
    pulse_int_rst();
    for (int i = 0; i < 80; i++) begin
      send_ser(0);
      check("windup_acc", longint'(dut.acc), m_acc);
      if (last_sat == 2'b10) break;
    end
    check("windup_reached", last_sat, 2);
    clamp_acc = longint'(dut.acc);
    for (int i = 0; i < 3; i++) begin
      send_ser(0);
      check("windup_frozen", longint'(dut.acc), clamp_acc);
      check("windup_out", last_dat, 100);
    end
    for (int i = 0; i < 2; i++) begin
      send_ser(200);
      if (last_sat == 2'b00) break;
    end
    check("windup_release", last_sat, 0);

    // Integrator hold and clear
    set_max = 14'sd8191; set_sp = 14'sd50;
    pulse_int_rst();
    for (int i = 0; i < 10; i++) send_ser(0);
    check("accum_acc", longint'(dut.acc), m_acc);
    hold_val = longint'(dut.acc);
    int_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_ser(0);
      check("hold_acc", longint'(dut.acc), hold_val);
    end
    int_hold = 1'b0;
    pulse_int_rst();
    check("int_rst_acc", longint'(dut.acc), 0);
    send_ser(0);
    check("post_clr_acc", longint'(dut.acc), m_acc);

    // Random stream with backpressure: integrator active, limits never reached
    chk_lat = 1'b0;
    pulse_int_rst();
    set_kp = DWK'(int'($urandom_range(0, 4000)) - 2000);
    set_ki = DWK'(int'($urandom_range(0, 600)) - 300);
    set_kd = DWK'(int'($urandom_range(0, 1000)) - 500);
    bp_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      set_sp = DWI'(int'($urandom_range(0, 2000)) - 1000);
      send(int'($urandom_range(0, 2000)) - 1000);
      gap();
    end
    drain();

    // Random stream with backpressure: full-range gains and random limits
    set_ki = '0;
    for (int blk = 0; blk < 8; blk++) begin
      set_kp = DWK'(int'($urandom_range(0, 16383)) - 8192);
      set_kd = DWK'(int'($urandom_range(0, 16383)) - 8192);
      a = int'($urandom_range(0, 16383)) - 8192;
      b = int'($urandom_range(0, 16383)) - 8192;
      if ((a > b) != ($urandom_range(0, 3) == 0)) begin t = a; a = b; b = t; end
      set_min = DWO'(a); set_max = DWO'(b);
      for (int i = 0; i < 50; i++) begin
        set_sp = DWI'(int'($urandom_range(0, 16383)) - 8192);
        send(int'($urandom_range(0, 16383)) - 8192);
        gap();
      end
      drain();
    end
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drain();

    // Reset with three samples in flight
    set_kp = 14'sd4096; set_kd = 14'sd2048; set_ki = '0; set_sp = '0;
    set_min = -14'sd8192; set_max = 14'sd8191;
    send(-100);
    send(-200);
    send(-300);
    rstn = 1'b0;
    #1;
    check("mid_rst_vld", sto_vld, 0);
    check("mid_rst_dat", sto_dat, 0);
    check("mid_rst_sat", sat_o, 0);
    check("mid_rst_rdy", sti_rdy, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    sb_q.delete();
    m_acc = 0; m_dprev = 0; m_sat = 2'b00;
    chk_lat = 1'b1;
    send_ser(-400);
    check("post_rst_dat", last_dat, 1200);
    check("post_rst_sat", last_sat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
